// File: rtl/i2s_frame_transceiver.sv
// I2S / left-justified master transceiver: one free-running counter derives MCLK/SCLK/LRCK,
// a stereo TX frame is serialised from a valid/ready holding register and a stereo RX frame is deserialised.
module i2s_frame_transceiver #(
  parameter int DATA_W        = 24,
  parameter int SLOT_W        = 32,
  parameter int SCLK_DIV_LOG2 = 4,
  parameter int MCLK_DIV_LOG2 = 1,
  parameter int MODE          = 0,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic              clk_audio,
  input  logic              reset,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic              sd_tx,
  input  logic              sd_rx,
  input  logic [DATA_W-1:0] tx_l,
  input  logic [DATA_W-1:0] tx_r,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_l,
  output logic [DATA_W-1:0] rx_r,
  output logic              rx_valid,
  input  logic              loopback,
  output logic              underrun,
  input  logic              clr_underrun
);

  localparam int FW = $clog2(2 * SLOT_W);
  localparam int CW = SCLK_DIV_LOG2 + FW;
  localparam int unsigned LS = (MODE != 0) ? 0 : 1;
  localparam int unsigned RS = SLOT_W + LS;
  localparam logic LR_INV = (MODE != 0);
  localparam logic [SCLK_DIV_LOG2-1:0] SCLK_MID = {1'b1, {(SCLK_DIV_LOG2-1){1'b0}}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
  logic [DATA_W-1:0] rxsh_l_q, rxsh_l_d, rxsh_r_q, rxsh_r_d;
  logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              sd_tx_q, sd_tx_d;
  logic              wrap, underrun_set;
  logic [FW-1:0]     f_d;
  logic [1:0]        kind_d;

  // {left, right} membership of a slot index in the data window
  function automatic logic [1:0] slot_kind(input logic [FW-1:0] f);
    int unsigned fi;
    fi = 32'(f);
    slot_kind = 2'b00;
    if (fi >= LS && fi < LS + DATA_W) slot_kind = 2'b10;
    else if (fi >= RS && fi < RS + DATA_W) slot_kind = 2'b01;
  endfunction

  function automatic logic slot_bit(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                    input logic [FW-1:0] f);
    logic [1:0]        kind;
    int unsigned       fi;
    logic [DATA_W-1:0] w;
    kind = slot_kind(f);
    fi   = 32'(f);
    w    = '0;
    if (kind[1]) w = l >> (LS + DATA_W - 1 - fi);
    else if (kind[0]) w = r >> (RS + DATA_W - 1 - fi);
    slot_bit = w[0];
  endfunction

  always_comb begin
    cnt_d        = cnt_q + CW'(1);
    wrap         = &cnt_q;
    f_d          = cnt_d[CW-1:SCLK_DIV_LOG2];
    kind_d       = slot_kind(f_d);
    hold_full_d  = hold_full_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    frm_l_d      = frm_l_q;
    frm_r_d      = frm_r_q;
    underrun_set = 1'b0;
    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_l_d    = tx_l;
      hold_r_d    = tx_r;
    end
    // Frame boundary: the frame just received is published and the next TX frame chosen
    if (wrap) begin
      if (loopback) begin
        frm_l_d = rxsh_l_q;
        frm_r_d = rxsh_r_q;
      end else if (hold_full_q) begin
        frm_l_d     = hold_l_q;
        frm_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_set = 1'b1;
        if (UNDERRUN_ZERO != 0) begin
          frm_l_d = '0;
          frm_r_d = '0;
        end
      end
    end
    underrun_d = underrun_set ? 1'b1 : (clr_underrun ? 1'b0 : underrun_q);
    sd_tx_d = sd_tx_q;
    if (cnt_d[SCLK_DIV_LOG2-1:0] == '0) sd_tx_d = slot_bit(frm_l_d, frm_r_d, f_d);
    rxsh_l_d = rxsh_l_q;
    rxsh_r_d = rxsh_r_q;
    if (cnt_d[SCLK_DIV_LOG2-1:0] == SCLK_MID) begin
      if (kind_d[1]) rxsh_l_d = (rxsh_l_q << 1) | DATA_W'(sd_rx);
      if (kind_d[0]) rxsh_r_d = (rxsh_r_q << 1) | DATA_W'(sd_rx);
    end
    rx_valid_d = wrap;
    rx_l_d     = wrap ? rxsh_l_q : rx_l_q;
    rx_r_d     = wrap ? rxsh_r_q : rx_r_q;
  end

  always_ff @(posedge clk_audio or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      frm_l_q     <= '0;
      frm_r_q     <= '0;
      sd_tx_q     <= 1'b0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      frm_l_q     <= frm_l_d;
      frm_r_q     <= frm_r_d;
      sd_tx_q     <= sd_tx_d;
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // Payload storage needs no reset: it is only consumed once the matching control says so
  always_ff @(posedge clk_audio) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
    rxsh_l_q <= rxsh_l_d;
    rxsh_r_q <= rxsh_r_d;
  end

  assign mclk     = cnt_q[MCLK_DIV_LOG2-1];
  assign sclk     = cnt_q[SCLK_DIV_LOG2-1];
  assign lrck     = cnt_q[CW-1] ^ LR_INV;
  assign sd_tx    = sd_tx_q;
  assign tx_ready = !hold_full_q && !reset;
  assign rx_l     = rx_l_q;
  assign rx_r     = rx_r_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_frame_transceiver.sv
// Directed bench for i2s_frame_transceiver: three instances (I2S, left-justified, zero-on-underrun)
// share stimulus; a codec model feeds sd_rx and scoreboards hold expected TX frames and RX pairs.
module tb_i2s_frame_transceiver;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, tx_valid, loopback, clr_underrun;
  logic [DW-1:0] tx_l, tx_r;
  logic          sd_rx_a, sd_rx_b, sd_rx_c;
  logic          mclk_a, sclk_a, lrck_a, sd_tx_a, tx_ready_a, rx_valid_a, underrun_a;
  logic          mclk_b, sclk_b, lrck_b, sd_tx_b, tx_ready_b, rx_valid_b, underrun_b;
  logic          mclk_c, sclk_c, lrck_c, sd_tx_c, tx_ready_c, rx_valid_c, underrun_c;
  logic [DW-1:0] rx_l_a, rx_r_a, rx_l_b, rx_r_b, rx_l_c, rx_r_c;

  i2s_frame_transceiver #(.DATA_W(DW), .SLOT_W(32), .SCLK_DIV_LOG2(4), .MCLK_DIV_LOG2(1),
                          .MODE(0), .UNDERRUN_ZERO(0)) u_a (
    .clk_audio(clk), .reset(reset), .mclk(mclk_a), .sclk(sclk_a), .lrck(lrck_a),
    .sd_tx(sd_tx_a), .sd_rx(sd_rx_a), .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid),
    .tx_ready(tx_ready_a), .rx_l(rx_l_a), .rx_r(rx_r_a), .rx_valid(rx_valid_a),
    .loopback(loopback), .underrun(underrun_a), .clr_underrun(clr_underrun));

  i2s_frame_transceiver #(.DATA_W(DW), .SLOT_W(32), .SCLK_DIV_LOG2(4), .MCLK_DIV_LOG2(1),
                          .MODE(1), .UNDERRUN_ZERO(0)) u_b (
    .clk_audio(clk), .reset(reset), .mclk(mclk_b), .sclk(sclk_b), .lrck(lrck_b),
    .sd_tx(sd_tx_b), .sd_rx(sd_rx_b), .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid),
    .tx_ready(tx_ready_b), .rx_l(rx_l_b), .rx_r(rx_r_b), .rx_valid(rx_valid_b),
    .loopback(loopback), .underrun(underrun_b), .clr_underrun(clr_underrun));

  i2s_frame_transceiver #(.DATA_W(DW), .SLOT_W(32), .SCLK_DIV_LOG2(4), .MCLK_DIV_LOG2(1),
                          .MODE(0), .UNDERRUN_ZERO(1)) u_c (
    .clk_audio(clk), .reset(reset), .mclk(mclk_c), .sclk(sclk_c), .lrck(lrck_c),
    .sd_tx(sd_tx_c), .sd_rx(sd_rx_c), .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid),
    .tx_ready(tx_ready_c), .rx_l(rx_l_c), .rx_r(rx_r_c), .rx_valid(rx_valid_c),
    .loopback(loopback), .underrun(underrun_c), .clr_underrun(clr_underrun));

  int            checks = 0;
  int            failures = 0;
  int            tcnt;
  logic          wrapped;
  int            clk_bad;
  logic [DW-1:0] codec_l, codec_r;
  logic [63:0]   cap_a, cap_b, cap_c;
  logic [63:0]   txq_a[$], txq_b[$], txq_c[$];
  logic [2*DW-1:0] rxq[$];

  // Serial bit carried in slot s when the data starts d slots after each LRCK edge
  function automatic logic ser_bit(input logic [DW-1:0] l, input logic [DW-1:0] r, input int s, input int d);
    logic [DW-1:0] w;
    w = '0;
    if (s >= d && s < d + DW) w = l >> (DW - 1 - (s - d));
    else if (s >= 32 + d && s < 32 + d + DW) w = r >> (DW - 1 - (s - 32 - d));
    return w[0];
  endfunction

  // Whole 64-slot frame, slot 0 in bit 63
  function automatic logic [63:0] img(input logic [DW-1:0] l, input logic [DW-1:0] r, input int d);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < 64; s++) v = {v[62:0], ser_bit(l, r, s, d)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    txq_a.push_back(a);
    txq_b.push_back(b);
    txq_c.push_back(c);
  endtask

  task automatic tick();
    logic            e_m, e_s, e_l, e_v;
    logic [2*DW-1:0] e;
    @(posedge clk);
    if (reset) begin
      tcnt    = 0;
      wrapped = 1'b0;
    end else begin
      if (tcnt == 1023) wrapped = 1'b1;
      tcnt = (tcnt + 1) % 1024;
    end
    @(negedge clk);
    e_m = tcnt[0];
    e_s = tcnt[3];
    e_l = tcnt[9];
    e_v = wrapped && (tcnt == 0);
    if ({mclk_a, sclk_a, lrck_a, rx_valid_a} !== {e_m, e_s, e_l, e_v}) clk_bad++;
    if ({mclk_b, sclk_b, lrck_b, rx_valid_b} !== {e_m, e_s, ~e_l, e_v}) clk_bad++;
    if ({mclk_c, sclk_c, lrck_c, rx_valid_c} !== {e_m, e_s, e_l, e_v}) clk_bad++;
    if (rx_valid_a === 1'b1 && rxq.size() > 0) begin
      e = rxq.pop_front();
      chk("rx_pair_a", 64'({rx_l_a, rx_r_a}), 64'(e));
      chk("rx_pair_b", 64'({rx_l_b, rx_r_b}), 64'(e));
      chk("rx_pair_c", 64'({rx_l_c, rx_r_c}), 64'(e));
    end
    if (tcnt[3:0] == 4'd8) begin
      cap_a = {cap_a[62:0], sd_tx_a};
      cap_b = {cap_b[62:0], sd_tx_b};
      cap_c = {cap_c[62:0], sd_tx_c};
    end
    sd_rx_a = ser_bit(codec_l, codec_r, tcnt / 16, 1);
    sd_rx_b = ser_bit(codec_l, codec_r, tcnt / 16, 0);
    sd_rx_c = sd_rx_a;
  endtask

  // Runs to the last cycle of the current frame and compares the captured sd_tx frames
  task automatic run_frame();
    do tick(); while (tcnt != 1023);
    chk("tx_frame_a", cap_a, txq_a.pop_front());
    chk("tx_frame_b", cap_b, txq_b.pop_front());
    chk("tx_frame_c", cap_c, txq_c.pop_front());
    chk("clocks_rx_valid", 64'(clk_bad), 64'd0);
    clk_bad = 0;
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_l = '0; tx_r = '0; loopback = 1'b0; clr_underrun = 1'b0;
    codec_l = '0; codec_r = '0; sd_rx_a = 1'b0; sd_rx_b = 1'b0; sd_rx_c = 1'b0;
    tcnt = 0; wrapped = 1'b0; clk_bad = 0; cap_a = '0; cap_b = '0; cap_c = '0;
    repeat (3) tick();
    chk("rst_clk_sd_a", 64'({mclk_a, sclk_a, lrck_a, sd_tx_a}), 64'd0);
    chk("rst_lrck_b", 64'(lrck_b), 64'd1);
    chk("rst_rx_a", 64'({rx_l_a, rx_r_a, rx_valid_a}), 64'd0);
    chk("rst_flags_a", 64'({tx_ready_a, underrun_a}), 64'd0);

    reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(tx_ready_a), 64'd1);
    codec_l = 24'h123456; codec_r = 24'h800001;
    rxq.push_back({24'h123456, 24'h800001});
    tick();
    tx_l = 24'hA5A5A5; tx_r = 24'h0F0F0F; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ready_full", 64'(tx_ready_a), 64'd0);
    push_tx('0, '0, '0);
    push_tx(img(24'hA5A5A5, 24'h0F0F0F, 1), img(24'hA5A5A5, 24'h0F0F0F, 0), img(24'hA5A5A5, 24'h0F0F0F, 1));
    repeat (2) push_tx(img(24'hA5A5A5, 24'h0F0F0F, 1), img(24'hA5A5A5, 24'h0F0F0F, 0), '0);
    run_frame();
    tick();
    chk("ready_at_wrap", 64'(tx_ready_a), 64'd1);
    chk("no_underrun_f1", 64'({underrun_a, underrun_b, underrun_c}), 64'd0);
    run_frame();
    tick();
    chk("underrun_f2", 64'({underrun_a, underrun_b, underrun_c}), 64'h7);
    run_frame();
    run_frame();

    clr_underrun = 1'b1;
    tick();
    chk("underrun_set_wins", 64'({underrun_a, underrun_b, underrun_c}), 64'h7);
    tick();
    clr_underrun = 1'b0;
    chk("underrun_cleared", 64'({underrun_a, underrun_b, underrun_c}), 64'd0);

    codec_l = 24'h00FFEE; codec_r = 24'h13579B; loopback = 1'b1;
    rxq.push_back({24'h00FFEE, 24'h13579B});
    tx_l = 24'h111111; tx_r = 24'h222222; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ready_full_lb", 64'(tx_ready_a), 64'd0);
    push_tx(img(24'hA5A5A5, 24'h0F0F0F, 1), img(24'hA5A5A5, 24'h0F0F0F, 0), '0);
    push_tx(img(24'h00FFEE, 24'h13579B, 1), img(24'h00FFEE, 24'h13579B, 0), img(24'h00FFEE, 24'h13579B, 1));
    push_tx(img(24'h111111, 24'h222222, 1), img(24'h111111, 24'h222222, 0), img(24'h111111, 24'h222222, 1));
    run_frame();
    tick();
    loopback = 1'b0;
    chk("lb_ready_kept", 64'(tx_ready_a), 64'd0);
    chk("lb_no_underrun", 64'({underrun_a, underrun_b, underrun_c}), 64'd0);
    run_frame();
    tick();
    chk("ready_after_hold_load", 64'(tx_ready_a), 64'd1);
    chk("hold_load_no_underrun", 64'({underrun_a, underrun_b, underrun_c}), 64'd0);
    run_frame();

    tick();
    tx_l = 24'h333333; tx_r = 24'h444444; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    while (tcnt != 300) tick();
    chk("pre_rst_full", 64'(tx_ready_a), 64'd0);
    chk("pre_rst_underrun", 64'(underrun_a), 64'd1);
    reset = 1'b1;
    tcnt = 0;
    wrapped = 1'b0;
    #1;
    chk("mid_rst_clk_sd_a", 64'({mclk_a, sclk_a, lrck_a, sd_tx_a}), 64'd0);
    chk("mid_rst_lrck_b", 64'(lrck_b), 64'd1);
    chk("mid_rst_rx_a", 64'({rx_l_a, rx_r_a, rx_valid_a}), 64'd0);
    chk("mid_rst_flags", 64'({tx_ready_a, underrun_a, underrun_b, underrun_c}), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("ready_after_mid_rst", 64'(tx_ready_a), 64'd1);
    push_tx('0, '0, '0);
    run_frame();
    tick();
    chk("first_frame_underrun", 64'({underrun_a, underrun_b, underrun_c}), 64'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
